// File: rtl/inst_loader.sv
// Byte-stream instruction loader: parses MAGIC, word count, big-endian words and an
// XOR checksum, writes each word to instruction memory, and gates the datapath via lock.
module inst_loader #(
  parameter int unsigned WORDS = 64,
  parameter logic [7:0]  MAGIC = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [5:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        lock,
  output logic        err,
  output logic [6:0]  words_loaded
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   n_q, n_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]   csum_q, csum_d;
  logic [COUNT_W-1:0]  words_loaded_q, words_loaded_d;

  logic accept;
  logic start;

  assign accept = rx_valid && rx_ready;
  // A header byte restarts a load from any resting state.
  assign start  = accept && (rx_data == MAGIC) &&
                  (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q            <= '0;
      word_q         <= '0;
      byte_cnt_q     <= '0;
      csum_q         <= '0;
      words_loaded_q <= '0;
    end else begin
      n_q            <= n_d;
      word_q         <= word_d;
      byte_cnt_q     <= byte_cnt_d;
      csum_q         <= csum_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (accept) begin
          if (rx_data == '0 || 32'(rx_data) > WORDS) state_d = S_ERR;
          else                                        state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_cnt_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (8'(words_loaded_q) + 8'd1 < n_q) state_d = S_DATA;
        else                                 state_d = S_CHECK;
      end
      S_CHECK: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    n_d            = n_q;
    word_d         = word_q;
    byte_cnt_d     = byte_cnt_q;
    csum_d         = csum_q;
    words_loaded_d = words_loaded_q;
    if (start) begin
      words_loaded_d = '0;
      csum_d         = '0;
      byte_cnt_d     = '0;
    end
    if (state_q == S_COUNT && accept) begin
      n_d = rx_data;
    end
    // Shift left so the first byte of a word ends up in bits 31:24.
    if (state_q == S_DATA && accept) begin
      word_d     = {word_q[WORD_W-BYTE_W-1:0], rx_data};
      csum_d     = csum_q ^ rx_data;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
    if (state_q == S_WRITE) begin
      words_loaded_d = words_loaded_q + 7'd1;
    end
  end

  // Output decode; the write strobe is masked by reset so no write lands on a reset edge.
  always_comb begin
    rx_ready     = (state_q != S_WRITE);
    imem_we      = (state_q == S_WRITE) && !reset;
    imem_addr    = words_loaded_q[5:0];
    imem_wdata   = word_q;
    lock         = (state_q == S_DONE);
    err          = (state_q == S_ERR);
    words_loaded = words_loaded_q;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 The module SHALL have parameter WORDS, default 64, meaning the instruction-memory depth in 32-bit words.
REQ-002 The module SHALL have parameter MAGIC, default 8'hA5, meaning the load-start header byte.
REQ-003 The module SHALL have port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-004 The module SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 The module SHALL have port rx_data  input  8  meaning the incoming byte-stream data.
REQ-006 The module SHALL have port rx_valid  input  1  meaning rx_data is valid this cycle.
REQ-007 The module SHALL have port rx_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-008 The module SHALL have port imem_we  output  1  meaning the instruction-memory write strobe.
REQ-009 The module SHALL have port imem_addr  output  6  meaning the instruction word index.
REQ-010 The module SHALL have port imem_wdata  output  32  meaning the instruction word to write.
REQ-011 The module SHALL have port lock  output  1  meaning the datapath run enable; high only after a verified load.
REQ-012 The module SHALL have port err  output  1  meaning the last load failed.
REQ-013 The module SHALL have port words_loaded  output  7  meaning the number of words written in the current or last load.

Function
REQ-014 A byte SHALL be accepted only on a rising edge where rx_valid=1 and rx_ready=1; all other rx_data values are ignored.
REQ-015 The FSM SHALL have states IDLE, COUNT, DATA, WRITE, CHECK, DONE and ERR.
REQ-016 rx_ready SHALL be 1 in every state except WRITE, where it is 0.
REQ-017 In IDLE, accepting MAGIC SHALL go to COUNT, clear words_loaded, clear the checksum and clear err; any other byte SHALL be discarded and the FSM stays in IDLE.
REQ-018 In COUNT, the accepted byte SHALL be latched as N; N=0 or N>WORDS SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-019 In DATA, bytes SHALL be assembled big-endian: the 1st byte goes to bits 31:24 and the 4th byte to bits 7:0; every data byte is XORed into an 8-bit checksum.
REQ-020 After the 4th byte of a word is accepted, the FSM SHALL go to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=words_loaded[5:0] and imem_wdata=the assembled word; words_loaded increments at the end of that cycle.
REQ-022 From WRITE, the FSM SHALL return to DATA if the incremented words_loaded < N, else go to CHECK.
REQ-023 In CHECK, an accepted byte equal to the running checksum SHALL go to DONE; any other value SHALL go to ERR.
REQ-024 In DONE, lock SHALL be 1 and err SHALL be 0.
REQ-025 In ERR, lock SHALL be 0 and err SHALL be 1.
REQ-026 In DONE or ERR, accepting MAGIC SHALL behave as in IDLE (restart): lock drops to 0 on the next cycle and err clears; other bytes SHALL be discarded.
REQ-027 imem_we SHALL be 0 in all states other than WRITE; imem_addr and imem_wdata are don't-care while imem_we=0.
REQ-028 lock SHALL be 0 in every state except DONE.
REQ-029 There SHALL be no timeout; a stalled rx stream holds the current state indefinitely.
REQ-030 The byte-within-word counter SHALL wrap 3->0 on each word.
REQ-031 Words already written before an ERR SHALL remain in memory; err flags the load as invalid.

Reset
REQ-032 When reset=1 at a rising edge, the FSM SHALL go to IDLE with imem_we=0, lock=0, err=0, words_loaded=0, checksum=0 and the byte counter=0.
REQ-033 reset SHALL override any simultaneous byte acceptance, including a reset arriving mid-word or in WRITE, where no write occurs on that edge.
REQ-034 After reset, rx_ready SHALL be 1.

Verification
REQ-035 Bench scenario: send A5, 01, 12 34 56 78, checksum 0x08 -> one imem_we pulse with addr=0 and wdata=0x12345678, then DONE with lock=1 and words_loaded=1.
REQ-036 Bench scenario: send A5, 02, 8 data bytes, wrong checksum -> two writes (addr 0 and 1), then err=1 and lock=0.
REQ-037 Bench scenario: send A5, 00, and separately A5, 41 -> ERR immediately after the count byte, with no imem_we pulses.
REQ-038 Bench scenario: hold rx_valid=1 continuously during a load -> rx_ready=0 exactly in each WRITE cycle and no byte is lost; 4-byte words take 5 cycles each.
REQ-039 Bench scenario: assert reset after the 2nd data byte, then send a complete valid 1-word load -> the correct word is written at addr 0 and lock=1.
REQ-040 Bench scenario: in DONE, send 0x00 then A5 -> 0x00 is ignored with lock still 1; after A5, lock=0 and the FSM is in COUNT.
